// File: rtl/equiv_run_ctrl.sv
// equiv_run_ctrl
//   Runs one equivalence pass over the two DUT copies of the harness. A seeded
//   Galois LFSR produces the stimulus, which is driven to both copies. y_1 and
//   y_2 are compared LAT cycles later. The block counts mismatches, captures
//   the first failing vector and reports pass/fail when the run ends.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start, abort      run request (IDLE only) / stop issuing vectors
//   num_vectors, seed run length and LFSR seed, both sampled on an accepted start
//   stim, stim_valid  registered stimulus to both DUT copies
//   y_1, y_2          outputs of the two DUT copies
//   busy, done, pass  run status; done is a one-cycle pulse, pass is held
//   mismatch_cnt      saturating count of compare failures
//   first_fail_*      index, y_1 and y_2 of the first failing vector
module equiv_run_ctrl #(
  parameter int STIM_W = 72,
  parameter int Y_W    = 91,
  parameter int LAT    = 2,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_vectors,
  input  logic [31:0]       seed,
  output logic [STIM_W-1:0] stim,
  output logic              stim_valid,
  input  logic [Y_W-1:0]    y_1,
  input  logic [Y_W-1:0]    y_2,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [Y_W-1:0]    first_fail_y1,
  output logic [Y_W-1:0]    first_fail_y2
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       DRAIN_LAST = 4'(LAT - 1);
  localparam logic [31:0]      LFSR_TAPS  = 32'h8020_0003;

  state_t             state;
  logic [CNT_W-1:0]   nv_q;
  logic [31:0]        seed_q;
  logic [31:0]        lfsr;
  logic [31:0]        lfsr_next;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   idx_next;
  logic [CNT_W-1:0]   stim_idx;
  logic [3:0]         drain_cnt;
  logic [STIM_W-1:0]  stim_next;
  logic [LAT-1:0]     vpipe;
  logic [CNT_W-1:0]   ipipe [LAT];
  logic               fail;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  assign idx_next  = idx + CNT_ONE;
  // Low STIM_W bits of {lfsr, lfsr[15:0], lfsr[31:16], ~lfsr}.
  assign stim_next = STIM_W'({lfsr, lfsr[15:0], lfsr[31:16], ~lfsr});
  assign fail      = vpipe[LAT-1] && (y_1 != y_2);
  assign busy      = (state == SEED) || (state == RUN) || (state == DRAIN);

  // Sequencer and stimulus generation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      nv_q       <= '0;
      seed_q     <= '0;
      lfsr       <= 32'h1;
      idx        <= '0;
      stim_idx   <= '0;
      drain_cnt  <= '0;
      stim       <= '0;
      stim_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      done       <= 1'b0;
      stim_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            nv_q   <= num_vectors;
            seed_q <= seed;
            idx    <= '0;
            state  <= SEED;
          end
        end
        SEED: begin
          lfsr      <= (seed_q == '0) ? 32'h1 : seed_q;
          drain_cnt <= '0;
          state     <= (nv_q == '0) ? DRAIN : RUN;
        end
        RUN: begin
          stim       <= stim_next;
          stim_valid <= 1'b1;
          stim_idx   <= idx;
          idx        <= idx_next;
          lfsr       <= lfsr_next;
          // The vector issued in this cycle still counts when abort is seen.
          if ((idx_next == nv_q) || abort) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid/index pipeline aligned with the DUT output latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        ipipe[i] <= '0;
      end
    end else begin
      vpipe[0] <= stim_valid;
      ipipe[0] <= stim_idx;
      for (int unsigned i = 1; i < LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        ipipe[i] <= ipipe[i-1];
      end
    end
  end

  // Compare bookkeeping and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_y1  <= '0;
      first_fail_y2  <= '0;
      pass           <= 1'b0;
    end else if ((state == IDLE) && start) begin
      mismatch_cnt   <= '0;
      first_fail_idx <= '0;
      first_fail_y1  <= '0;
      first_fail_y2  <= '0;
      pass           <= 1'b0;
    end else begin
      if (fail) begin
        if (mismatch_cnt != '1) begin
          mismatch_cnt <= mismatch_cnt + CNT_ONE;
        end
        if (mismatch_cnt == '0) begin
          first_fail_idx <= ipipe[LAT-1];
          first_fail_y1  <= y_1;
          first_fail_y2  <= y_2;
        end
      end
      // The last compare lands in the DONE cycle, so fold it in here.
      if (state == DONE) begin
        pass <= (mismatch_cnt == '0) && !fail;
      end
    end
  end

endmodule
